// File: rtl/bus_interface_unit.sv
// 8085 external-bus machine-cycle sequencer (T1..T4 with ALE, RD/WR and READY).
// Define BIU_WAIT_EN to honour ready and insert TW wait states; otherwise cycle lengths are fixed.
module bus_interface_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  cycle_type,
  input  logic [15:0] address,
  input  logic [7:0]  dbus_in,
  output logic [7:0]  dbus_out,
  output logic        dbus_oe,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ad_out,
  input  logic [7:0]  ad_in,
  output logic        ad_oe,
  output logic [7:0]  a_hi,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  output logic        io_m,
  output logic        s1,
  output logic        s0,
  input  logic        ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  localparam logic [2:0] CT_FETCH = 3'd0;
  localparam logic [2:0] CT_MRD   = 3'd1;
  localparam logic [2:0] CT_MWR   = 3'd2;
  localparam logic [2:0] CT_IORD  = 3'd3;
  localparam logic [2:0] CT_IOWR  = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [2:0]  ctype;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done_r;
  logic        dbus_oe_r;
  logic        accept;
  logic        is_read;
  logic        is_write;
  logic        is_io;
  logic        strobe_phase;

  assign accept   = (state == S_IDLE) && start && (cycle_type <= CT_IOWR);
  assign is_read  = (ctype == CT_FETCH) || (ctype == CT_MRD) || (ctype == CT_IORD);
  assign is_write = (ctype == CT_MWR) || (ctype == CT_IOWR);
  assign is_io    = (ctype == CT_IORD) || (ctype == CT_IOWR);
  assign strobe_phase = (state == S_T2) || (state == S_TW) || (state == S_T3);

`ifndef BIU_WAIT_EN
  logic unused_ready;
  assign unused_ready = ready;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
`ifdef BIU_WAIT_EN
      S_T2, S_TW: state_nxt = ready ? S_T3 : S_TW;
`else
      S_T2:   state_nxt = S_T3;
`endif
      S_T3:   state_nxt = (ctype == CT_FETCH) ? S_T4 : S_IDLE;
      S_T4:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ctype     <= CT_FETCH;
      addr      <= 16'h0000;
      done_r    <= 1'b0;
      dbus_oe_r <= 1'b0;
      // A reset that aborts a cycle must not disturb the last read data; a reset
      // seen in IDLE (e.g. held for two or more clocks at power-up) clears it.
      if (state == S_IDLE) rdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      done_r    <= (state == S_T3);
      dbus_oe_r <= (state == S_T3) && is_read;
      if ((state == S_T3) && is_read) rdata <= ad_in;
      if (accept) begin
        ctype <= cycle_type;
        wdata <= dbus_in;
        addr  <= ((cycle_type == CT_IORD) || (cycle_type == CT_IOWR)) ?
                 {address[7:0], address[7:0]} : address;
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign ale      = (state == S_T1);
  assign rd_n     = !(strobe_phase && is_read);
  assign wr_n     = !(strobe_phase && is_write);
  assign ad_oe    = (state == S_T1) || (strobe_phase && is_write);
  assign ad_out   = (state == S_T1) ? addr[7:0] :
                    (strobe_phase && is_write) ? wdata : 8'h00;
  assign a_hi     = addr[15:8];
  assign io_m     = busy && is_io;
  assign s1       = busy && is_read;
  assign s0       = busy && ((ctype == CT_FETCH) || is_write);
  assign done     = done_r;
  assign dbus_oe  = dbus_oe_r;
  assign dbus_out = rdata;

endmodule

// File: doc/bus_interface_unit.md
# bus_interface_unit

Multiplexed external-bus machine-cycle sequencer for the 8085 core. It runs one machine cycle per request (opcode fetch, memory read/write, I/O read/write) through T1–T4 with ALE, RD/WR strobes and READY wait states. It sits between the register file's address output, the internal 8-bit data bus (DBUS) and the external AD/A bus. It is the reader/writer end that supplies DBUS data to the instruction register, register file and ALU.

## Interface
- No parameters.
- clk  in  1  system clock; one T-state per cycle
- rst  in  1  synchronous, active-high reset
- start  in  1  request a machine cycle; accepted only when busy=0
- cycle_type  in  3  0=opcode fetch, 1=mem read, 2=mem write, 3=I/O read, 4=I/O write; 5–7 illegal
- address  in  16  cycle address from register file, sampled on accept
- dbus_in  in  8  internal DBUS write data, sampled on accept
- dbus_out  out  8  read-data latch (rdata)
- dbus_oe  out  1  bus_interface_unit drives DBUS with rdata
- busy  out  1  cycle in progress
- done  out  1  one-cycle completion pulse
- ad_out  out  8  external AD[7:0] drive value
- ad_in  in  8  external AD[7:0] sampled value
- ad_oe  out  1  AD[7:0] output enable
- a_hi  out  8  external A[15:8]
- ale  out  1  address latch enable
- rd_n, wr_n  out  1 each  active-low strobes
- io_m, s1, s0  out  1 each  8085 status
- ready  in  1  external wait request; 0 inserts wait states

## Operation
- FSM states: IDLE, T1, T2, TW, T3, T4.
- IDLE + start + legal type → T1.
  - Latch type, address, dbus_in into wdata.
  - For I/O types, the latched address is {address[7:0], address[7:0]}.
- start with an illegal type, or while busy=1, is ignored. No state change.
- Status (io_m,s1,s0), held from T1 through the last T-state:
  - fetch 0,1,1
  - mem rd 0,1,0
  - mem wr 0,0,1
  - I/O rd 1,1,0
  - I/O wr 1,0,1
  - IDLE 0,0,0
- T1 outputs: ale=1, ad_oe=1, ad_out=addr[7:0], a_hi=addr[15:8].
- T2, TW and T3 outputs, ale=0:
  - Read types: ad_oe=0, rd_n=0.
  - Write types: ad_oe=1, ad_out=wdata, wr_n=0.
- Transitions:
  - T1→T2 always.
  - T2 or TW: ready=1 → T3, ready=0 → TW. TW repeats without limit.
- T3:
  - Read types load rdata←ad_in on the closing edge.
  - Fetch → T4; all others → IDLE.
- T4 (fetch only): strobes inactive, ad_oe=0, then → IDLE.
- done=1 for exactly one cycle after T3 closes:
  - In T4 for fetch.
  - In the first IDLE cycle for the other types.
- dbus_oe=1 only while done=1 and the type is a read or fetch.
- dbus_out holds rdata until the next read completes. Write cycles never change rdata.
- a_hi holds its last value in IDLE.
- busy=1 in T1..T4. busy=0 in IDLE, including the done cycle, so back-to-back start is accepted there.

## Timing
- Zero wait states: fetch is T1,T2,T3,T4 (4 clocks); the other types are 3 clocks. Each wait state adds 1 clock.
- Latency from the start edge: ale at +1; done at +4 for all types when ready=1.
- All outputs are registered or decoded from state only. No combinational path from ready or ad_in to any output.
- Reset values: state IDLE, ale=0, rd_n=1, wr_n=1, ad_oe=0, ad_out=0, a_hi=0, io_m=s1=s0=0, busy=0, done=0, dbus_oe=0, rdata=0.
- rst asserted mid-cycle (any state, including TW):
  - The next edge returns to IDLE with reset values.
  - No done pulse and no rdata update.
- rst has priority over start on the same edge.

## Configuration
- BIU_WAIT_EN defined:
  - ready is honoured.
  - TW is reachable as described above.
- BIU_WAIT_EN undefined:
  - ready is ignored.
  - T2 always goes to T3 and TW is not compiled.
  - Cycle lengths are fixed at 4 (fetch) and 3 (others).

## Test plan
- Fetch, address=0x0100, ready=1, ad_in=0x43 in T3:
  - ale pulses in T1 with ad_out=0x00 and a_hi=0x01.
  - rd_n low for 2 cycles.
  - done in T4 with dbus_oe=1 and dbus_out=0x43.
  - Status 0,1,1.
- Mem read 0x2050 with ready=0 for 2 cycles in T2/TW:
  - 2 TW states.
  - rd_n low for 4 cycles.
  - rdata=ad_in from T3.
  - done 6 cycles after start.
- Mem write 0x1234 with dbus_in=0xA5:
  - ad_out=0x34 in T1, then 0xA5 with wr_n=0 for T2–T3.
  - done without dbus_oe.
  - rdata unchanged.
- I/O write to port 0x20, address input 0xFF20:
  - a_hi=0x20 and T1 ad_out=0x20.
  - Status 1,0,1.
- rst during TW:
  - Next cycle is IDLE with rd_n=1, done=0, busy=0.
  - rdata keeps its old value.
- Back-to-back requests:
  - start in the done cycle of a mem read is accepted, and the next ale follows 1 cycle later.
  - start with cycle_type=6, or start during busy, is ignored.
